mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single-ported RAM between the instruction-fetch and data-access requests that the request unit produces.
- Grants one requester at a time and registers the address and store data at grant.
- Holds the RAM control stable until the RAM signals completion, then returns a one-cycle ihit or dhit with the load data.
- Data has priority. A streak counter prevents instruction starvation, and a timeout counter flags a RAM that never responds.

Parameters:
- MAX_DSTREAK, 4: maximum consecutive data grants while iREN is pending before instruction is forced.
- TIMEOUT, 64: cycles in an access state without ram_ready before abort and error.

Ports:
- CLK  input  1  system clock
- nRST  input  1  synchronous, active-low reset
- iREN  input  1  instruction read request, held until ihit
- iaddr  input  32  instruction address (word_t)
- dREN  input  1  data read request, held until dhit
- dWEN  input  1  data write request, held until dhit
- daddr  input  32  data address
- dstore  input  32  data to write
- ram_ready  input  1  RAM access complete this cycle
- ramload  input  32  RAM read data, valid with ram_ready
- ramREN  output  1  RAM read enable
- ramWEN  output  1  RAM write enable
- ramaddr  output  32  RAM address (latched)
- ramstore  output  32  RAM write data (latched)
- ihit  output  1  instruction access done, one-cycle pulse
- iload  output  32  fetched instruction, valid when ihit
- dhit  output  1  data access done, one-cycle pulse
- dload  output  32  loaded data, valid when dhit
- mem_err  output  1  sticky error flag

Behaviour:
- Clock and reset: one clock, CLK. nRST is synchronous active-low, sampled only at the CLK rising edge.
- FSM states: IDLE, IACC, DRD, DWR.
- Reset (nRST=0 at edge):
  - state=IDLE, dstreak=0, tcnt=0, mem_err=0, latched addr/store=0.
  - ramREN=ramWEN=ihit=dhit=0, ramaddr=ramstore=0, iload=dload=0.
  - Reset mid-access aborts the access with no hit.
- IDLE arbitration, decided combinationally and applied at the edge:
  - Requests pending: if (dREN|dWEN) and not (iREN and dstreak==MAX_DSTREAK), grant data. Else if iREN, grant instruction. Else stay IDLE.
  - Data grant: dWEN → DWR, else DRD. Latch daddr and dstore. Increment dstreak if iREN, saturating at MAX_DSTREAK; otherwise clear it.
  - Instruction grant: → IACC. Latch iaddr. Clear dstreak.
  - dREN and dWEN both high: treated as a write. mem_err is set.
- Access states:
  - IACC and DRD drive ramREN=1; DWR drives ramWEN=1. ramaddr and ramstore come from the latches, stable for the whole access.
  - ihit = (state==IACC)&ram_ready; dhit = (state∈{DRD,DWR})&ram_ready. Both are combinational and last exactly one cycle.
  - iload = ramload gated by ihit; dload = ramload gated by dhit, else 0. A DWR hit gives dload=0.
  - On ram_ready: → IDLE and tcnt=0. The requester changes its request at that same edge, so IDLE sees only fresh requests.
- Latency:
  - A request in IDLE at cycle t puts the RAM access on the bus at t+1. With ram_ready at t+1, the hit is at t+1.
  - Every access leaves one IDLE cycle between back-to-back grants.
- Timeout:
  - tcnt increments on each access cycle without ram_ready.
  - When tcnt reaches TIMEOUT-1 without ready: → IDLE, no hit, mem_err=1 (sticky until reset).
- Request dropped mid-access: the access still completes and the hit pulses. The datapath ignores it.
- Request present with ram_ready already high in IDLE: ignored. ram_ready is meaningful only in access states.
- No outputs are driven X; all outputs are 0 outside their valid state.

Decomposition:
- cpu_types_pkg: add the enum arb_state_t {IDLE, IACC, DRD, DWR}. word_t and the width constants are already there.
- Add a mem_arbiter_if interface with modports arb and tb, matching the existing interface style.
- One natural sub-module, arb_timeout_ctr: a parameterized counter with clear/enable/expire. The rest is a single FSM module.

Test Plan:
- Reset mid-access: assert nRST=0 while in IACC → next cycle ramREN=0, state IDLE, no ihit, mem_err=0.
- Instruction read: iREN=1, iaddr=0x0000_0040, ram_ready one cycle after ramREN with ramload=0x2408_0001 → ramaddr=0x40, ihit=1 for one cycle, iload=0x24080001.
- Simultaneous read requests: iREN=1, dREN=1, daddr=0x100 → DRD first, dhit; then IACC, ihit; ramaddr 0x100 then iaddr.
- Data write: dWEN=1, daddr=0x200, dstore=0xDEAD_BEEF, ready after 3 cycles → ramWEN high 3 cycles, ramstore=0xDEADBEEF stable, dhit pulses once, dload=0.
- Starvation guard: iREN held, data requests back-to-back with MAX_DSTREAK=4 → exactly 4 data grants, then IACC, then data resumes.
- Timeout: dREN=1, ram_ready never asserted, TIMEOUT=64 → ramREN high 64 cycles, returns to IDLE, no dhit, mem_err=1 held until nRST.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: word width, word_t and the memory arbiter state encoding.
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  // Arbiter states: idle, instruction fetch, data read, data write.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IACC = 2'd1,
    DRD  = 2'd2,
    DWR  = 2'd3
  } arb_state_t;

  // True while the arbiter owns the RAM on behalf of the data side.
  function automatic logic is_data_state(arb_state_t s);
    return (s == DRD) || (s == DWR);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the request-unit / RAM signals that surround the memory arbiter.
interface mem_arbiter_if (
  input logic CLK
);
  import cpu_types_pkg::*;

  logic  nRST;
  logic  iREN;
  word_t iaddr;
  logic  dREN;
  logic  dWEN;
  word_t daddr;
  word_t dstore;
  logic  ram_ready;
  word_t ramload;
  logic  ramREN;
  logic  ramWEN;
  word_t ramaddr;
  word_t ramstore;
  logic  ihit;
  word_t iload;
  logic  dhit;
  word_t dload;
  logic  mem_err;

  modport arb (
    input  CLK, nRST, iREN, iaddr, dREN, dWEN, daddr, dstore, ram_ready, ramload,
    output ramREN, ramWEN, ramaddr, ramstore, ihit, iload, dhit, dload, mem_err
  );

  modport tb (
    input  CLK, ramREN, ramWEN, ramaddr, ramstore, ihit, iload, dhit, dload, mem_err,
    output nRST, iREN, iaddr, dREN, dWEN, daddr, dstore, ram_ready, ramload
  );

endinterface

// File: rtl/arb_timeout_ctr.sv
// Counts access cycles without RAM completion and flags the cycle on which the
// access must be abandoned (the LIMIT-th consecutive waiting cycle).
module arb_timeout_ctr #(
  parameter int LIMIT = 64
) (
  input  logic CLK,
  input  logic nRST,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int            CW   = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] tcnt;

  assign expire = en && (tcnt == LAST);

  // Wait-cycle counter: restarts whenever the access ends or is abandoned.
  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!nRST) begin
      tcnt <= '0;
    end else if (clr || expire) begin
      tcnt <= '0;
    end else if (en) begin
      tcnt <= tcnt + CW'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported RAM between instruction fetch and data access.
// Data wins arbitration unless it has already taken MAX_DSTREAK grants in a
// row while a fetch waits; a RAM that never answers is abandoned after TIMEOUT
// cycles and latches mem_err.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int MAX_DSTREAK = 4,
  parameter int TIMEOUT     = 64
) (
  input  logic  CLK,
  input  logic  nRST,
  input  logic  iREN,
  input  word_t iaddr,
  input  logic  dREN,
  input  logic  dWEN,
  input  word_t daddr,
  input  word_t dstore,
  input  logic  ram_ready,
  input  word_t ramload,
  output logic  ramREN,
  output logic  ramWEN,
  output word_t ramaddr,
  output word_t ramstore,
  output logic  ihit,
  output word_t iload,
  output logic  dhit,
  output word_t dload,
  output logic  mem_err
);

  localparam int            SW         = $clog2(MAX_DSTREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);

  arb_state_t    state;
  logic [SW-1:0] dstreak;
  word_t         addr_q;
  word_t         store_q;

  logic in_access;
  logic grant_d;
  logic grant_i;
  logic tmo_clr;
  logic tmo_en;
  logic tmo_expire;

  // Arbitration and timeout control, evaluated every cycle and applied at the edge.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    grant_d   = 1'b0;
    grant_i   = 1'b0;
    in_access = (state != IDLE);
    tmo_en    = 1'b0;
    tmo_clr   = 1'b1;
    if (state == IDLE) begin
      grant_d = (dREN || dWEN) && !(iREN && (dstreak == STREAK_MAX));
      grant_i = !grant_d && iREN;
    end else begin
      tmo_en  = !ram_ready;
      tmo_clr = ram_ready;
    end
  end

  arb_timeout_ctr #(
    .LIMIT (TIMEOUT)
  ) u_timeout (
    .CLK    (CLK),
    .nRST   (nRST),
    .clr    (tmo_clr),
    .en     (tmo_en),
    .expire (tmo_expire)
  );

  // Arbiter FSM: grant, hold the latched request, return on completion or timeout.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state   <= IDLE;
      dstreak <= '0;
      mem_err <= 1'b0;
      addr_q  <= '0;
      store_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            // A simultaneous read+write request is illegal; serve it as a write.
            state   <= dWEN ? DWR : DRD;
            addr_q  <= daddr;
            store_q <= dstore;
            if (iREN) begin
              dstreak <= (dstreak == STREAK_MAX) ? dstreak : dstreak + SW'(1);
            end else begin
              dstreak <= '0;
            end
            if (dREN && dWEN) begin
              mem_err <= 1'b1;
            end
          end else if (grant_i) begin
            state   <= IACC;
            addr_q  <= iaddr;
            dstreak <= '0;
          end
        end
        default: begin
          if (ram_ready) begin
            state <= IDLE;
          end else if (tmo_expire) begin
            state   <= IDLE;
            mem_err <= 1'b1;
          end
        end
      endcase
    end
  end

  // RAM control follows the registered state; address/data come only from the latches.
  assign ramREN   = (state == IACC) || (state == DRD);
  assign ramWEN   = (state == DWR);
  assign ramaddr  = in_access ? addr_q : '0;
  assign ramstore = ramWEN ? store_q : '0;

  // Completion pulses last exactly the cycle the RAM reports ready.
  assign ihit  = (state == IACC) && ram_ready;
  assign dhit  = is_data_state(state) && ram_ready;
  assign iload = ihit ? ramload : '0;
  assign dload = ((state == DRD) && ram_ready) ? ramload : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a request driver and RAM responder feed the
// DUT, expected hits are queued at issue time and a negedge monitor checks them.
module tb_mem_arbiter;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] store;
  } dreq_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] load;
  } exp_t;

  logic        CLK;
  logic        nRST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        ram_ready;
  logic [31:0] ramload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic        ihit;
  logic [31:0] iload;
  logic        dhit;
  logic [31:0] dload;
  logic        mem_err;

  mem_arbiter #(
    .MAX_DSTREAK (4),
    .TIMEOUT     (64)
  ) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .iREN      (iREN),
    .iaddr     (iaddr),
    .dREN      (dREN),
    .dWEN      (dWEN),
    .daddr     (daddr),
    .dstore    (dstore),
    .ram_ready (ram_ready),
    .ramload   (ramload),
    .ramREN    (ramREN),
    .ramWEN    (ramWEN),
    .ramaddr   (ramaddr),
    .ramstore  (ramstore),
    .ihit      (ihit),
    .iload     (iload),
    .dhit      (dhit),
    .dload     (dload),
    .mem_err   (mem_err)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // RAM contents are a fixed function of the address.
  assign ramload = ram_ready ? (ramaddr ^ 32'h2408_0041) : 32'h0;

  int checks   = 0;
  int failures = 0;

  logic [31:0] iq[$];
  dreq_t       dq[$];
  exp_t        iexp[$];
  exp_t        dexp[$];
  string       hit_log;
  bit          i_done;
  bit          d_done;
  bit          drv_en;
  int          ram_lat;
  int          acc_cyc;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_s(string name, string act, string exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
    end
  endtask

  task automatic push_i(logic [31:0] a, logic [31:0] load);
    exp_t e;
    e.addr = a;
    e.load = load;
    iq.push_back(a);
    iexp.push_back(e);
  endtask

  task automatic push_d(logic rd, logic wr, logic [31:0] a, logic [31:0] st, logic [31:0] load);
    dreq_t r;
    exp_t  e;
    r.rd    = rd;
    r.wr    = wr;
    r.addr  = a;
    r.store = st;
    e.addr  = a;
    e.load  = load;
    dq.push_back(r);
    dexp.push_back(e);
  endtask

  task automatic wait_drain(string name);
    int n = 0;
    while ((iexp.size() != 0 || dexp.size() != 0 || iq.size() != 0 || dq.size() != 0) && n < 500) begin
      @(negedge CLK);
      n++;
    end
    check({name, "_drained"}, 32'(n < 500), 32'd1);
    repeat (2) @(negedge CLK);
  endtask

  task automatic reset_dut();
    @(posedge CLK);
    #1 nRST = 1'b0;
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;
  endtask

  // Requester and RAM responder: requests drop at the hit edge, ready after ram_lat cycles.
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (i_done) begin
        if (iq.size() != 0) iq.delete(0);
        i_done = 1'b0;
      end
      if (d_done) begin
        if (dq.size() != 0) dq.delete(0);
        d_done = 1'b0;
      end
      if (drv_en) begin
        iREN  = (iq.size() != 0);
        iaddr = (iq.size() != 0) ? iq[0] : 32'h0;
        if (dq.size() != 0) begin
          dREN   = dq[0].rd;
          dWEN   = dq[0].wr;
          daddr  = dq[0].addr;
          dstore = dq[0].store;
        end else begin
          dREN   = 1'b0;
          dWEN   = 1'b0;
          daddr  = 32'h0;
          dstore = 32'h0;
        end
      end
      if (ramREN || ramWEN) acc_cyc++;
      else acc_cyc = 0;
      ram_ready = (ramREN || ramWEN) && (acc_cyc == ram_lat);
    end
  end

  // Monitor: pop the expected response on every hit; check idle gating every cycle.
  always @(negedge CLK) begin
    exp_t e;
    check("quiet_outputs",
          32'(((!ihit) && (iload != 0)) || ((!dhit) && (dload != 0)) ||
              (ramREN && ramWEN) || (ihit && dhit)), 32'd0);
    if (ihit) begin
      check("ihit_expected", 32'(iexp.size() != 0), 32'd1);
      if (iexp.size() != 0) begin
        e = iexp.pop_front();
        check("ihit_addr", ramaddr, e.addr);
        check("iload", iload, e.load);
      end
      hit_log = {hit_log, "I"};
      i_done  = 1'b1;
    end
    if (dhit) begin
      check("dhit_expected", 32'(dexp.size() != 0), 32'd1);
      if (dexp.size() != 0) begin
        e = dexp.pop_front();
        check("dhit_addr", ramaddr, e.addr);
        check("dload", dload, e.load);
      end
      hit_log = {hit_log, "D"};
      d_done  = 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int wc;
    int bad;
    int n;
    bit saw_hit;

    nRST = 1'b0; iREN = 1'b0; iaddr = 32'h0; dREN = 1'b0; dWEN = 1'b0;
    daddr = 32'h0; dstore = 32'h0; ram_ready = 1'b0;
    drv_en = 1'b1; ram_lat = 1; acc_cyc = 0; hit_log = ""; i_done = 1'b0; d_done = 1'b0;

    // Reset state
    repeat (3) @(negedge CLK);
    check("rst_ramREN",   32'(ramREN),  32'd0);
    check("rst_ramWEN",   32'(ramWEN),  32'd0);
    check("rst_ramaddr",  ramaddr,      32'h0);
    check("rst_ramstore", ramstore,     32'h0);
    check("rst_hits",     32'({ihit, dhit}), 32'd0);
    check("rst_mem_err",  32'(mem_err), 32'd0);
    @(posedge CLK);
    #1 nRST = 1'b1;

    // Single instruction read
    hit_log = ""; ram_lat = 1;
    push_i(32'h0000_0040, 32'h2408_0001);
    wait_drain("iread");
    check_s("iread_order", hit_log, "I");

    // Simultaneous read requests: data first, then the fetch
    hit_log = ""; ram_lat = 2;
    push_i(32'h0000_0044, 32'h2408_0005);
    push_d(1'b1, 1'b0, 32'h0000_0100, 32'h0, 32'h2408_0141);
    wait_drain("simul");
    check_s("simul_order", hit_log, "DI");

    // Data write, RAM ready on the third access cycle
    hit_log = ""; ram_lat = 3;
    push_d(1'b0, 1'b1, 32'h0000_0200, 32'hDEAD_BEEF, 32'h0);
    wc = 0; bad = 0; n = 0;
    while (n < 50) begin
      @(negedge CLK);
      n++;
      if (ramWEN) begin
        wc++;
        if (ramstore !== 32'hDEAD_BEEF || ramaddr !== 32'h0000_0200) bad++;
      end
      if (dhit) break;
    end
    check("wr_wen_cycles", 32'(wc), 32'd3);
    check("wr_store_stable", 32'(bad), 32'd0);
    wait_drain("write");
    check_s("write_order", hit_log, "D");
    check("wr_no_err", 32'(mem_err), 32'd0);

    // Starvation guard: fetch held, five data reads queued
    hit_log = ""; ram_lat = 1;
    push_i(32'h0000_0080, 32'h2408_00C1);
    push_d(1'b1, 1'b0, 32'h0000_0400, 32'h0, 32'h2408_0441);
    push_d(1'b1, 1'b0, 32'h0000_0410, 32'h0, 32'h2408_0451);
    push_d(1'b1, 1'b0, 32'h0000_0420, 32'h0, 32'h2408_0461);
    push_d(1'b1, 1'b0, 32'h0000_0430, 32'h0, 32'h2408_0471);
    push_d(1'b1, 1'b0, 32'h0000_0440, 32'h0, 32'h2408_0401);
    wait_drain("streak");
    check_s("streak_order", hit_log, "DDDDID");

    // Read and write together: served as a write, error latched
    hit_log = ""; ram_lat = 1;
    push_d(1'b1, 1'b1, 32'h0000_0300, 32'h1234_5678, 32'h0);
    wait_drain("rdwr");
    check("rdwr_mem_err", 32'(mem_err), 32'd1);
    reset_dut();
    @(negedge CLK);
    check("rdwr_err_cleared", 32'(mem_err), 32'd0);

    // Reset in the middle of a fetch
    drv_en = 1'b0; ram_lat = -1; hit_log = "";
    @(posedge CLK);
    #1 iREN = 1'b1; iaddr = 32'h0000_0600;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!ramREN && n < 20);
    check("rstmid_in_iacc", 32'(ramREN), 32'd1);
    nRST = 1'b0; iREN = 1'b0; iaddr = 32'h0;
    @(negedge CLK);
    check("rstmid_ramREN",  32'(ramREN),  32'd0);
    check("rstmid_ramaddr", ramaddr,      32'h0);
    check("rstmid_mem_err", 32'(mem_err), 32'd0);
    @(posedge CLK);
    #1 nRST = 1'b1;
    repeat (2) @(negedge CLK);
    check_s("rstmid_no_hit", hit_log, "");

    // Timeout: RAM never answers a data read
    @(posedge CLK);
    #1 dREN = 1'b1; daddr = 32'h0000_0500;
    wc = 0; n = 0; saw_hit = 1'b0;
    while (n < 300) begin
      @(negedge CLK);
      n++;
      if (dhit) saw_hit = 1'b1;
      if (ramREN) wc++;
      else if (wc > 0) break;
    end
    dREN = 1'b0; daddr = 32'h0;
    check("tmo_ren_cycles", 32'(wc), 32'd64);
    check("tmo_no_dhit", 32'(saw_hit), 32'd0);
    check("tmo_mem_err", 32'(mem_err), 32'd1);
    repeat (4) @(negedge CLK);
    check("tmo_err_sticky", 32'(mem_err), 32'd1);
    check("tmo_back_idle", 32'({ramREN, ramWEN}), 32'd0);
    reset_dut();
    @(negedge CLK);
    check("tmo_err_cleared", 32'(mem_err), 32'd0);

    check("final_iexp_empty", 32'(iexp.size()), 32'd0);
    check("final_dexp_empty", 32'(dexp.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
